// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the receiver and the future transmitter.
// The receiver's optional 2-of-3 majority sampling is enabled by UART_RX_MAJORITY_EN.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Truncating divide; callers rely on the integer result as the bit period.
    function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Output-side handshake of the UART receiver: payload, flags and valid/ready.
// The receiver drives the master modport, the byte consumer uses slave.
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
) ();

    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output overrun,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output data_ready
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high line; resets to 1 so the
// line reads idle while the chain fills.
module uart_rx_sync (
    input  logic clk,
    input  logic nRst,
    input  logic d,
    output logic q
);

    logic [1:0] ff_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            ff_q <= 2'b11;
        end else begin
            ff_q <= {ff_q[0], d};
        end
    end

    assign q = ff_q[1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, parity/frame flags, valid/ready output
// register with overrun pulse. Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter parity_e     PARITY     = PAR_NONE,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                   clk,
    input  logic                   nRst,
    input  logic                   enable,
    input  logic                   rx,
    uart_rx_param_if.master        out_if,
    output logic                   receiving,
    output logic [3:0]             bits_received
);

    localparam int unsigned CLKS  = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W = $clog2(CLKS);
    localparam int unsigned HALF  = CLKS / 2;

`ifdef UART_RX_MAJORITY_EN
    // Decision sits one count after the nominal point so the third vote is available.
    localparam int unsigned START_PT = HALF;
`else
    localparam int unsigned START_PT = HALF - 1;
`endif

    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_PT);
    localparam logic [CNT_W-1:0] BIT_CNT   = CNT_W'(CLKS - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]           bits_q, bits_d;
    logic [1:0]           stop_q, stop_d;
    logic                 perr_acc_q, perr_acc_d;
    logic                 ferr_acc_q, ferr_acc_d;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic rx_s;
    logic sample;
    logic sample_pt;
    logic par_x;
    logic deliver;

    uart_rx_sync u_sync (
        .clk  (clk),
        .nRst (nRst),
        .d    (rx),
        .q    (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q;

    // Free-running history: at the decision count it holds the two preceding samples.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            maj_q <= 2'b11;
        end else begin
            maj_q <= {maj_q[0], rx_s};
        end
    end

    assign sample = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);
`else
    assign sample = rx_s;
`endif

    assign sample_pt = (state_q == START) ? (cnt_q == START_CNT) : (cnt_q == BIT_CNT);
    assign par_x     = ^{shreg_q, sample};

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            bits_q     <= '0;
            stop_q     <= '0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            bits_q     <= bits_d;
            stop_q     <= stop_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        shreg_d    = shreg_q;
        bits_d     = bits_q;
        stop_d     = stop_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        deliver    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (sample_pt) begin
                    cnt_d      = '0;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                    // A high start sample was a glitch: drop it silently.
                    state_d    = sample ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_pt) begin
                    cnt_d   = '0;
                    shreg_d = {sample, shreg_q[DATA_BITS-1:1]};
                    bits_d  = bits_q + 4'd1;
                    stop_d  = '0;
                    if (bits_q == LAST_DATA) begin
                        state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (sample_pt) begin
                    cnt_d      = '0;
                    perr_acc_d = (PARITY == PAR_ODD) ? ~par_x : par_x;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (sample_pt) begin
                    cnt_d      = '0;
                    ferr_acc_d = ferr_acc_q | ~sample;
                    stop_d     = stop_q + 2'd1;
                    if (stop_q == LAST_STOP) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            bits_d = '0;
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;

        if (deliver) begin
            if (!valid_q || out_if.data_ready) begin
                data_d  = shreg_q;
                perr_d  = perr_acc_q;
                ferr_d  = ferr_acc_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && out_if.data_ready) begin
            valid_d = 1'b0;
        end
    end

    assign out_if.data_out   = data_q;
    assign out_if.data_valid = valid_q;
    assign out_if.parity_err = perr_q;
    assign out_if.frame_err  = ferr_q;
    assign out_if.overrun    = ovr_q;
    assign receiving         = (state_q != IDLE);
    assign bits_received     = bits_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an 8N1 and an 8E1 receiver at 16 clocks/bit, a frame-level
// output model compared every cycle, plus directed literal checks.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int unsigned CF = 160_000;
    localparam int unsigned BR = 10_000;
    localparam int C     = 16;
    localparam int H     = 8;
    localparam int LAT_N = 2 + H + 9 * C;
    localparam int LAT_E = 2 + H + 10 * C;

    logic       clk  = 1'b0;
    logic       nRst = 1'b0;
    logic [1:0] en   = 2'b11;
    logic [1:0] rx   = 2'b00;
    logic [1:0] rdy  = 2'b00;
    logic       recv_n, recv_e;
    logic [3:0] bits_n, bits_e;

    uart_rx_param_if #(.DATA_BITS(8)) if_n ();
    uart_rx_param_if #(.DATA_BITS(8)) if_e ();
    assign if_n.data_ready = rdy[0];
    assign if_e.data_ready = rdy[1];

    uart_rx_param #(
        .CLOCK_FREQ (CF),
        .BAUD_RATE  (BR),
        .DATA_BITS  (8),
        .PARITY     (PAR_NONE),
        .STOP_BITS  (1)
    ) dut_n (
        .clk           (clk),
        .nRst          (nRst),
        .enable        (en[0]),
        .rx            (rx[0]),
        .out_if        (if_n),
        .receiving     (recv_n),
        .bits_received (bits_n)
    );

    uart_rx_param #(
        .CLOCK_FREQ (CF),
        .BAUD_RATE  (BR),
        .DATA_BITS  (8),
        .PARITY     (PAR_EVEN),
        .STOP_BITS  (1)
    ) dut_e (
        .clk           (clk),
        .nRst          (nRst),
        .enable        (en[1]),
        .rx            (rx[1]),
        .out_if        (if_e),
        .receiving     (recv_e),
        .bits_received (bits_e)
    );

    always #5 clk = ~clk;

    logic [7:0] dout  [2];
    logic       dval  [2];
    logic       dperr [2];
    logic       dferr [2];
    logic       dovr  [2];
    logic       drecv [2];
    assign dout[0]  = if_n.data_out;
    assign dout[1]  = if_e.data_out;
    assign dval[0]  = if_n.data_valid;
    assign dval[1]  = if_e.data_valid;
    assign dperr[0] = if_n.parity_err;
    assign dperr[1] = if_e.parity_err;
    assign dferr[0] = if_n.frame_err;
    assign dferr[1] = if_e.frame_err;
    assign dovr[0]  = if_n.overrun;
    assign dovr[1]  = if_e.overrun;
    assign drecv[0] = recv_n;
    assign drecv[1] = recv_e;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    // Frame-level model of the output register.
    logic [7:0] m_data  [2];
    logic       m_valid [2];
    logic       m_perr  [2];
    logic       m_ferr  [2];
    logic       m_ovr   [2];
    int         pend_cyc  [2];
    logic [7:0] pend_data [2];
    logic       pend_perr [2];
    logic       pend_ferr [2];

    int   start_cyc [2];
    int   rise_cyc  [2];
    int   rise_cnt  [2];
    int   ovr_cnt   [2];
    logic prev_val  [2];
    int   bits_max      = 0;
    int   bits_step_err = 0;
    logic [3:0] bits_prev = 4'd0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_data[i] = '0; m_valid[i] = 0; m_perr[i] = 0; m_ferr[i] = 0; m_ovr[i] = 0;
            pend_cyc[i] = -1; start_cyc[i] = 0; rise_cyc[i] = 0; rise_cnt[i] = 0;
            ovr_cnt[i] = 0; prev_val[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (!nRst) begin
                    m_data[i] = '0; m_valid[i] = 0; m_perr[i] = 0; m_ferr[i] = 0; m_ovr[i] = 0;
                end else begin
                    m_ovr[i] = 0;
                    if (cyc == pend_cyc[i]) begin
                        if (!m_valid[i] || rdy[i]) begin
                            m_data[i] = pend_data[i];
                            m_perr[i] = pend_perr[i];
                            m_ferr[i] = pend_ferr[i];
                            m_valid[i] = 1;
                        end else begin
                            m_ovr[i] = 1;
                        end
                    end else if (m_valid[i] && rdy[i]) begin
                        m_valid[i] = 0;
                    end
                end
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("valid[%0d]", i), int'(dval[i]), int'(m_valid[i]));
                check($sformatf("data[%0d]", i), int'(dout[i]), int'(m_data[i]));
                check($sformatf("perr[%0d]", i), int'(dperr[i]), int'(m_perr[i]));
                check($sformatf("ferr[%0d]", i), int'(dferr[i]), int'(m_ferr[i]));
                check($sformatf("overrun[%0d]", i), int'(dovr[i]), int'(m_ovr[i]));
                if (dval[i] && !prev_val[i]) begin
                    rise_cyc[i] = cyc;
                    rise_cnt[i]++;
                end
                prev_val[i] = dval[i];
                if (dovr[i]) ovr_cnt[i]++;
            end
            if (bits_n != bits_prev) begin
                if (bits_n != 4'd0 && bits_n != bits_prev + 4'd1) bits_step_err++;
                if (int'(bits_n) > bits_max) bits_max = int'(bits_n);
                bits_prev = bits_n;
            end
        end
    end

    task automatic send(input int d, input logic [7:0] data, input logic pbit,
                        input logic stopv, input bit drop_en);
        start_cyc[d] = cyc;
        pend_cyc[d]  = cyc + 1 + ((d == 0) ? LAT_N : LAT_E);
        pend_data[d] = data;
        pend_perr[d] = (d == 1) ? ((^data) ^ pbit) : 1'b0;
        pend_ferr[d] = ~stopv;
        rx[d] = 1'b0;
        tick(C);
        if (drop_en) en[d] = 1'b0;
        for (int b = 0; b < 8; b++) begin
            rx[d] = data[b];
            tick(C);
        end
        if (d == 1) begin
            rx[d] = pbit;
            tick(C);
        end
        rx[d] = stopv;
        tick(C);
        rx[d] = 1'b1;
    endtask

    task automatic wait_idle(input int d, input int limit, input string name);
        int n = 0;
        while (drecv[d] && n < limit) begin
            tick(1);
            n++;
        end
        check(name, int'(drecv[d]), 0);
    endtask

    task automatic accept(input int d);
        rdy[d] = 1'b1;
        tick(1);
        rdy[d] = 1'b0;
    endtask

    initial begin
        int ovr0;
        int rise0;
        bit saw;
        bit nz;

        // Reset with rx held low and enable high.
        tick(3);
        check("rst_valid", int'(if_n.data_valid), 0);
        check("rst_data", int'(if_n.data_out), 0);
        check("rst_flags", int'({if_n.parity_err, if_n.frame_err, if_n.overrun}), 0);
        check("rst_recv_n", int'(recv_n), 0);
        check("rst_recv_e", int'(recv_e), 0);
        check("rst_bits", int'(bits_n), 0);
        nRst = 1'b1;
        tick(2);
        check("sync_recv_early", int'(recv_n), 0);
        tick(1);
        check("sync_recv_n", int'(recv_n), 1);
        check("sync_recv_e", int'(recv_e), 1);
        rx = 2'b11;
        wait_idle(0, 40, "rst_glitch_idle_n");
        wait_idle(1, 40, "rst_glitch_idle_e");
        tick(C);

        // 8N1 byte 0x0F, consumer not ready.
        send(0, 8'h0F, 1'b0, 1'b1, 1'b0);
        check("b0F_data", int'(if_n.data_out), 8'h0F);
        check("b0F_valid", int'(if_n.data_valid), 1);
        check("b0F_errs", int'({if_n.parity_err, if_n.frame_err}), 0);
        check("b0F_latency", rise_cyc[0] - start_cyc[0], 155);
        check("b0F_bits_max", bits_max, 8);
        check("b0F_bits_step", bits_step_err, 0);
        accept(0);
        check("b0F_accept_valid", int'(if_n.data_valid), 0);
        check("b0F_hold_data", int'(if_n.data_out), 8'h0F);
        tick(C);

        // Even parity: wrong then correct parity bit for 0x5A.
        send(1, 8'h5A, 1'b1, 1'b1, 1'b0);
        check("p5A_bad_data", int'(if_e.data_out), 8'h5A);
        check("p5A_bad_perr", int'(if_e.parity_err), 1);
        check("p5A_latency", rise_cyc[1] - start_cyc[1], 171);
        accept(1);
        tick(C);
        send(1, 8'h5A, 1'b0, 1'b1, 1'b0);
        check("p5A_ok_data", int'(if_e.data_out), 8'h5A);
        check("p5A_ok_perr", int'(if_e.parity_err), 0);
        check("p5A_ok_valid", int'(if_e.data_valid), 1);
        accept(1);
        tick(C);

        // Stop bit low for 0xA5; enable drops mid-frame and must block the trailing low.
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        check("fA5_recv_blocked", int'(recv_n), 0);
        tick(4);
        en[0] = 1'b1;
        check("fA5_data", int'(if_n.data_out), 8'hA5);
        check("fA5_ferr", int'(if_n.frame_err), 1);
        check("fA5_perr", int'(if_n.parity_err), 0);
        wait_idle(0, 40, "fA5_idle");
        accept(0);
        tick(C);

        // Start glitch shorter than half a bit.
        saw   = 0;
        nz    = 0;
        rise0 = rise_cnt[0];
        rx[0] = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k == 4) rx[0] = 1'b1;
            tick(1);
            if (recv_n) saw = 1;
            if (bits_n != 4'd0) nz = 1;
        end
        check("glitch_started", int'(saw), 1);
        check("glitch_idle", int'(recv_n), 0);
        check("glitch_bits", int'(nz), 0);
        check("glitch_no_valid", rise_cnt[0] - rise0, 0);
        tick(C);

        // Back-to-back with full output register: overrun.
        ovr0 = ovr_cnt[0];
        send(0, 8'h11, 1'b0, 1'b1, 1'b0);
        send(0, 8'h22, 1'b0, 1'b1, 1'b0);
        tick(2);
        check("b2b_full_data", int'(if_n.data_out), 8'h11);
        check("b2b_full_valid", int'(if_n.data_valid), 1);
        check("b2b_full_ovr", ovr_cnt[0] - ovr0, 1);
        accept(0);
        tick(C);

        // Back-to-back with ready on the delivery edge: no overrun.
        ovr0 = ovr_cnt[0];
        send(0, 8'h11, 1'b0, 1'b1, 1'b0);
        rdy[0] = 1'b1;
        send(0, 8'h22, 1'b0, 1'b1, 1'b0);
        tick(1);
        check("b2b_rdy_data", int'(if_n.data_out), 8'h22);
        check("b2b_rdy_ovr", ovr_cnt[0] - ovr0, 0);
        rdy[0] = 1'b0;
        tick(5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        total++;
        $display("FAIL timeout: simulation did not complete by cycle %0d", cyc);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
